// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the single-port OpenRAM front-end and its macro
// wrappers.
//   sram_op_e        : macro operation started by an accepted request
//   SRAM_DATA_WIDTH  : default macro word width
//   SRAM_ADDR_WIDTH  : default macro address width
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } sram_op_e;

   localparam int SRAM_DATA_WIDTH = 128;
   localparam int SRAM_ADDR_WIDTH = 10;

endpackage

// File: rtl/sram_rsp_fifo.sv
// -----------------------------------------------------------------------------
// sram_rsp_fifo
// Circular-buffer response FIFO for read data captured off the macro bus.
// The head entry is presented straight from the storage registers, so nothing
// downstream sees a combinational path from the push side.
// Ports:
//   clk, rstb        : clock, asynchronous active-low reset
//   push_i/push_data_i : write an entry (ignored when full and not popping)
//   pop_i            : consume the head entry (ignored when empty)
//   rd_valid_o       : FIFO holds at least one entry
//   rd_data_o        : head entry, forced to zero while empty
//   count_o          : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sram_rsp_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 2
) (
   input  logic                             clk,
   input  logic                             rstb,
   input  logic                             push_i,
   input  logic [WIDTH-1:0]                 push_data_i,
   input  logic                             pop_i,
   output logic                             rd_valid_o,
   output logic [WIDTH-1:0]                 rd_data_o,
   output logic [$clog2(DEPTH+1)-1:0]       count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign do_pop  = pop_i && (count_q != '0);
   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_push = push_i && ((count_q < CW'(DEPTH)) || do_pop);

   always_comb begin
      wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CW'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign rd_valid_o = (count_q != '0);
   assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
   assign count_o    = count_q;

endmodule

// File: rtl/sram_1rw_req_ctrl.sv
// -----------------------------------------------------------------------------
// sram_1rw_req_ctrl
// Valid/ready front-end for a single-port OpenRAM macro with a shared
// tri-state data bus. Accepted requests drive the macro pins in the same
// cycle; read data is captured one edge after issue and returned in order
// through a credit-limited response FIFO.
// Ports:
//   clk, rstb                  : clock (also the macro clock), async active-low reset
//   req_valid/req_ready        : request handshake
//   req_we, req_addr, req_wdata: request payload (1 = write)
//   rsp_valid/rsp_ready        : response handshake
//   rsp_rdata                  : read data, request order
//   sram_csb/web/oeb           : active-low macro controls
//   sram_addr                  : macro address
//   sram_data                  : shared macro data bus (driven here only on writes)
// Note: req_ready depends combinationally on rsp_ready.
// -----------------------------------------------------------------------------
module sram_1rw_req_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
   parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
   parameter int RSP_DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  rstb,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  sram_csb,
   output logic                  sram_web,
   output logic                  sram_oeb,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   inout  wire  [DATA_WIDTH-1:0] sram_data
);

   localparam int CW = $clog2(RSP_DEPTH + 1);

   logic                  run_q;
   logic                  rd_pend_q, rd_pend_d;
   logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
   logic [CW-1:0]         fifo_count;
   logic [CW:0]           credit_used;
   logic                  pop;
   logic                  acc;
   sram_op_e              op;

   assign pop = rsp_valid && rsp_ready;

   // Slots that will be occupied after this edge if a read is not accepted:
   // the in-flight read still needs one, a popped entry frees one.
   assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, rd_pend_q} - {{CW{1'b0}}, pop};

   // run_q is low throughout reset, so no request can be accepted then.
   // A write is held off during a data phase because the macro owns the bus.
   assign req_ready = run_q && !(rd_pend_q && req_we) &&
                      (req_we || (credit_used < (CW+1)'(RSP_DEPTH)));
   assign acc = req_valid && req_ready;

   always_comb begin
      op = IDLE;
      if (acc) begin
         op = req_we ? WRITE : READ;
      end
   end

   // Pin decode. A data phase with no new read repeats the last address,
   // which only produces a harmless extra read.
   always_comb begin
      sram_csb  = 1'b1;
      sram_web  = 1'b1;
      sram_oeb  = 1'b1;
      sram_addr = last_addr_q;
      unique case (op)
         WRITE: begin
            sram_csb  = 1'b0;
            sram_web  = 1'b0;
            sram_addr = req_addr;
         end
         READ: begin
            sram_csb  = 1'b0;
            sram_oeb  = 1'b0;
            sram_addr = req_addr;
         end
         default: begin
            if (rd_pend_q) begin
               sram_csb = 1'b0;
               sram_oeb = 1'b0;
            end
         end
      endcase
   end

   assign sram_data = (op == WRITE) ? req_wdata : {DATA_WIDTH{1'bz}};

   assign rd_pend_d   = (op == READ);
   assign last_addr_d = acc ? req_addr : last_addr_q;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         run_q       <= 1'b0;
         rd_pend_q   <= 1'b0;
         last_addr_q <= '0;
      end else begin
         run_q       <= 1'b1;
         rd_pend_q   <= rd_pend_d;
         last_addr_q <= last_addr_d;
      end
   end

   sram_rsp_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk         (clk),
      .rstb        (rstb),
      .push_i      (rd_pend_q),
      .push_data_i (sram_data),
      .pop_i       (rsp_ready),
      .rd_valid_o  (rsp_valid),
      .rd_data_o   (rsp_rdata),
      .count_o     (fifo_count)
   );

endmodule

// File: tb/tb_sram_1rw_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_1rw_req_ctrl
// Scoreboard bench: accepted requests update a reference memory and queue the
// expected read data; an independent monitor pops and compares responses.
// A small behavioural macro model sits on the shared bus.
// -----------------------------------------------------------------------------
module tb_sram_1rw_req_ctrl;

   localparam int DW = 32;
   localparam int AW = 6;
   localparam int RD = 2;
   localparam int NW = 1 << AW;

   logic          clk = 1'b0;
   logic          rstb = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_ready = 1'b0;
   wire           req_ready;
   wire           rsp_valid;
   wire  [DW-1:0] rsp_rdata;
   wire           sram_csb, sram_web, sram_oeb;
   wire  [AW-1:0] sram_addr;
   wire  [DW-1:0] sram_data;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic rand_done = 1'b0;

   logic [DW-1:0] exp_q [$];
   int            pop_cyc [$];
   logic [DW-1:0] ref_mem [NW];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sram_1rw_req_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .RSP_DEPTH  (RD)
   ) dut (
      .clk       (clk),
      .rstb      (rstb),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .sram_csb  (sram_csb),
      .sram_web  (sram_web),
      .sram_oeb  (sram_oeb),
      .sram_addr (sram_addr),
      .sram_data (sram_data)
   );

   // Behavioural single-port macro: acts on the control pins at the edge and
   // drives its last read word whenever output enable is low.
   logic [DW-1:0] macro_mem [NW];
   logic [DW-1:0] macro_dout = '0;
   always @(posedge clk) begin
      if (!sram_csb) begin
         if (!sram_web) macro_mem[sram_addr] <= sram_data;
         else           macro_dout <= macro_mem[sram_addr];
      end
   end
   assign sram_data = !sram_oeb ? macro_dout : {DW{1'bz}};

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard and monitor, sampled mid-cycle. Reset discards everything in flight.
   always @(negedge clk) begin
      if (!rstb) begin
         exp_q.delete();
      end else begin
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_rsp: actual=%0h required=no response (cycle %0d)", rsp_rdata, cyc);
            end else begin
               check("rsp_rdata", rsp_rdata, exp_q.pop_front());
               pop_cyc.push_back(cyc);
            end
         end
         if (!sram_csb) check("bus_contention", {31'd0, !(!sram_web && !sram_oeb)}, 1);
         if (req_valid && req_ready) begin
            if (req_we) ref_mem[req_addr] <= req_wdata;
            else        exp_q.push_back(ref_mem[req_addr]);
         end
      end
   end

   // Call at 1 time unit after a rising edge; returns 1 time unit after the
   // accepting edge with the pins seen in the accept cycle.
   task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int waits, output logic [2:0] pins, output logic [DW-1:0] bus);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      waits     = 0;
      forever begin
         @(negedge clk);
         if (req_ready) break;
         waits++;
         if (waits > 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: actual=no accept required=accept within 200 cycles");
            break;
         end
      end
      pins = {sram_csb, sram_web, sram_oeb};
      bus  = sram_data;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_pins"}, {29'd0, sram_csb, sram_web, sram_oeb}, 32'd7);
      check({tag, "_addr"}, {26'd0, sram_addr}, 0);
      check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 0);
      check({tag, "_rsp_rdata"}, rsp_rdata, 0);
      check({tag, "_req_ready"}, {31'd0, req_ready}, 0);
   endtask

   initial begin
      int            w, w3;
      logic [2:0]    p, p3;
      logic [DW-1:0] b, b3;
      logic [DW-1:0] a5;

      a5 = {(DW/8){8'hA5}};

      // Reset state
      #3;
      check_reset_outputs("reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstb = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;

      // Fill the whole macro with known data so every read has an expected value
      for (int i = 0; i < NW; i++) send(1'b1, AW'(i), $urandom, w, p, b);

      // Write then read of address 5, with one-cycle response latency
      send(1'b1, AW'(5), a5, w, p, b);
      check("t1_write_pins", {29'd0, p}, 32'd1);
      check("t1_write_bus", b, a5);
      send(1'b0, AW'(5), '0, w, p, b);
      check("t1_read_pins", {29'd0, p}, 32'd2);
      @(negedge clk);
      check("t1_dphase_pins", {29'd0, sram_csb, sram_web, sram_oeb}, 32'd2);
      check("t1_dphase_rsp_valid", {31'd0, rsp_valid}, 0);
      @(negedge clk);
      check("t1_rsp_valid", {31'd0, rsp_valid}, 1);
      check("t1_rsp_rdata", rsp_rdata, a5);
      @(posedge clk);
      #1;

      // Back-to-back reads, one response per cycle
      for (int i = 0; i < 4; i++) send(1'b1, AW'(i), DW'(10 + i), w, p, b);
      pop_cyc.delete();
      for (int i = 0; i < 4; i++) begin
         send(1'b0, AW'(i), '0, w, p, b);
         check("t2_read_no_stall", w, 0);
      end
      repeat (4) @(posedge clk);
      #1;
      check("t2_rsp_count", pop_cyc.size(), 4);
      if (pop_cyc.size() == 4)
         for (int i = 1; i < 4; i++) check("t2_rsp_consecutive", pop_cyc[i] - pop_cyc[i-1], 1);

      // Read immediately followed by write: one bubble for bus turnaround
      send(1'b0, AW'(1), '0, w, p, b);
      check("t3_read_no_stall", w, 0);
      send(1'b1, AW'(2), DW'(32'h0000_0077), w, p, b);
      check("t3_write_bubble", w, 1);
      check("t3_write_pins", {29'd0, p}, 32'd1);
      send(1'b0, AW'(2), '0, w, p, b);
      repeat (4) @(posedge clk);
      #1;

      // Credit limit with rsp_ready low
      rsp_ready = 1'b0;
      send(1'b0, AW'(0), '0, w, p, b);
      check("t4_first_accept", w, 0);
      send(1'b0, AW'(1), '0, w, p, b);
      check("t4_second_accept", w, 0);
      fork
         send(1'b0, AW'(3), '0, w3, p3, b3);
         begin
            repeat (5) @(posedge clk);
            #1;
            rsp_ready = 1'b1;
         end
      join
      check("t4_third_held", w3, 5);
      repeat (5) @(posedge clk);
      #1;
      check("t4_drained", exp_q.size(), 0);

      // Asynchronous reset during a read data phase
      send(1'b0, AW'(3), '0, w, p, b);
      #1;
      rstb = 1'b0;
      #1;
      check_reset_outputs("t5_midreset");
      repeat (2) @(negedge clk);
      rstb = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t5_no_stale_rsp", {31'd0, rsp_valid}, 0);
      end
      @(posedge clk);
      #1;
      send(1'b0, AW'(3), '0, w, p, b);
      repeat (4) @(posedge clk);
      #1;
      check("t5_new_read_done", exp_q.size(), 0);

      // Randomised traffic with random consumer backpressure
      fork
         begin
            for (int n = 0; n < 300; n++) begin
               repeat ($urandom_range(0, 2)) @(posedge clk);
               if (n != 0) #0;
               send(1'($urandom_range(0, 1)), AW'($urandom_range(0, NW - 1)), $urandom, w, p, b);
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               rsp_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      rsp_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("rand_all_responded", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard stop if something wedges beyond all bounded waits
   initial begin
      #400000;
      $display("FAIL global_timeout: actual=still running required=finished");
      $fatal(1, "global timeout");
   end

endmodule
